// File: rtl/partition_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : partition_dispatcher
//  Description : Read-side consumer of the partition FIFO. Pops one entry at
//                a time, checks that its grant is one-hot, decodes it to a
//                mapper index and presents the payload on a valid/ready port.
//                Each completed transfer pulses an ack to the granted mapper
//                and bumps a wrapping dispatch counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module partition_dispatcher #(
  parameter int NUM_OF_MAPPERS = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int COUNT_WIDTH    = 16,
  // Bits needed to hold the index NUM_OF_MAPPERS-1; equals ceil(log2(N))
  // for every legal N >= 2.
  localparam int ID_WIDTH      = $clog2(NUM_OF_MAPPERS)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic                                 fifo_empty,
  output logic                                 fifo_re,
  input  logic [NUM_OF_MAPPERS+DATA_WIDTH-1:0] fifo_dout,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic [ID_WIDTH-1:0]                  out_mapper_id,
  output logic [NUM_OF_MAPPERS-1:0]            mapper_ack,
  output logic                                 err_not_onehot,
  output logic [COUNT_WIDTH-1:0]               dispatch_count,
  output logic                                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LATCH = 2'd2,
    SEND  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [NUM_OF_MAPPERS-1:0] fifo_grant;
  logic [DATA_WIDTH-1:0]     fifo_payload;
  logic                      grant_onehot;
  logic [ID_WIDTH-1:0]       grant_index;
  logic                      handshake;

  assign fifo_grant   = fifo_dout[NUM_OF_MAPPERS+DATA_WIDTH-1:DATA_WIDTH];
  assign fifo_payload = fifo_dout[DATA_WIDTH-1:0];

  // Non-zero and clearing the lowest set bit leaves nothing: exactly one bit.
  assign grant_onehot = (fifo_grant != '0) &&
                        ((fifo_grant & (fifo_grant - NUM_OF_MAPPERS'(1))) == '0);

  // Transfer completes in SEND whenever downstream is ready.
  assign handshake = (state == SEND) && out_ready;

  // Moore outputs decoded straight from the state register, so an async
  // reset drops them immediately.
  assign fifo_re   = (state == FETCH);
  assign out_valid = (state == SEND);
  assign busy      = (state != IDLE);

  // Binary index of the grant bit; only meaningful when the grant is one-hot.
  always_comb begin
    grant_index = '0;
    for (int i = 0; i < NUM_OF_MAPPERS; i++) begin
      if (fifo_grant[i]) begin
        grant_index = ID_WIDTH'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: enable/fifo_empty matter only in IDLE, so an entry
  // in flight always runs to completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable && !fifo_empty) state_next = FETCH;
      FETCH:   state_next = LATCH;
      LATCH:   state_next = grant_onehot ? SEND : IDLE;
      SEND:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output payload and id: loaded once in LATCH, held through SEND.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_data      <= '0;
      out_mapper_id <= '0;
    end else if (state == LATCH && grant_onehot) begin
      out_data      <= fifo_payload;
      out_mapper_id <= grant_index;
    end
  end

  // Sticky malformed-grant flag; only reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_not_onehot <= 1'b0;
    end else if (state == LATCH && !grant_onehot) begin
      err_not_onehot <= 1'b1;
    end
  end

  // Completed-transfer counter, wraps naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dispatch_count <= '0;
    end else if (handshake) begin
      dispatch_count <= dispatch_count + COUNT_WIDTH'(1);
    end
  end

  // One-cycle ack to the source mapper, in the cycle after the handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mapper_ack <= '0;
    end else if (handshake) begin
      mapper_ack <= NUM_OF_MAPPERS'(1) << out_mapper_id;
    end else begin
      mapper_ack <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_partition_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_partition_dispatcher
//  Description : Scoreboard bench for partition_dispatcher. A FIFO model
//                feeds directed entries; expected outputs are queued at push
//                time and a monitor pops them on each handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_partition_dispatcher;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int IW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_re;
  logic [N+DW-1:0] fifo_dout = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_mapper_id;
  logic [N-1:0]  mapper_ack;
  logic          err_not_onehot;
  logic [CW-1:0] dispatch_count;
  logic          busy;

  partition_dispatcher #(
    .NUM_OF_MAPPERS(N),
    .DATA_WIDTH    (DW),
    .COUNT_WIDTH   (CW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .fifo_empty    (fifo_empty),
    .fifo_re       (fifo_re),
    .fifo_dout     (fifo_dout),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_mapper_id (out_mapper_id),
    .mapper_ack    (mapper_ack),
    .err_not_onehot(err_not_onehot),
    .dispatch_count(dispatch_count),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t            exp_q[$];
  logic [N+DW-1:0] fifo_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // FIFO model: read data appears the cycle after fifo_re.
  always @(posedge clock) begin
    if (fifo_re) begin
      if (fifo_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fifo_underflow: actual=read required=no_read");
      end else begin
        fifo_dout <= fifo_q.pop_front();
      end
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Monitor: scoreboard pop on handshake, ack follow-up, hold stability.
  logic          ack_pend = 1'b0;
  logic [N-1:0]  ack_exp = '0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic [IW-1:0] hold_id = '0;

  always @(negedge clock) begin
    if (reset) begin
      ack_pend   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (ack_pend) begin
        check("mapper_ack", mapper_ack, ack_exp);
        ack_pend = 1'b0;
      end else if (mapper_ack != '0) begin
        check("stray_ack", mapper_ack, 0);
      end
      if (stall_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_data);
        check("hold_id", out_mapper_id, hold_id);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: actual=data %0h id %0d required=none", out_data, out_mapper_id);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_mapper_id", out_mapper_id, e.id);
          ack_pend = 1'b1;
          ack_exp  = N'(1) << e.id;
        end
      end
      stall_prev = out_valid && !out_ready;
      hold_data  = out_data;
      hold_id    = out_mapper_id;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_good(input logic [N-1:0] g, input logic [DW-1:0] d, input logic [IW-1:0] id);
    exp_t e;
    e.id   = id;
    e.data = d;
    fifo_q.push_back({g, d});
    exp_q.push_back(e);
    fifo_empty = 1'b0;
  endtask

  task automatic push_bad(input logic [N-1:0] g, input logic [DW-1:0] d);
    fifo_q.push_back({g, d});
    fifo_empty = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge clock);
    while (!(fifo_q.size() == 0 && exp_q.size() == 0 && !busy) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_done_timeout: actual=busy required=idle within %0d cycles", budget);
    end
    @(negedge clock);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    @(negedge clock);
    while (!out_valid && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!out_valid) check("wait_valid_timeout", out_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int re_cyc[$];

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_fifo_re", fifo_re, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_id", out_mapper_id, 0);
    check("rst_ack", mapper_ack, 0);
    check("rst_err", err_not_onehot, 0);
    check("rst_count", dispatch_count, 0);
    check("rst_busy", busy, 0);
    step();
    reset = 1'b0;
    enable = 1'b1;
    out_ready = 1'b1;

    // Single entry and its latency
    step();
    push_good(4'b0100, 32'hDEADBEEF, 2'd2);
    @(negedge clock);
    check("t1_no_early_re", fifo_re, 0);
    @(negedge clock);
    check("t1_fifo_re", fifo_re, 1);
    @(negedge clock);
    check("t1_re_one_cycle", fifo_re, 0);
    check("t1_valid_latch", out_valid, 0);
    @(negedge clock);
    check("t1_valid_send", out_valid, 1);
    check("t1_data", out_data, 32'hDEADBEEF);
    check("t1_id", out_mapper_id, 2);
    @(negedge clock);
    check("t1_ack", mapper_ack, 4'b0100);
    check("t1_count", dispatch_count, 1);
    @(negedge clock);
    check("t1_ack_cleared", mapper_ack, 0);

    // Backpressure with a second entry waiting
    step();
    out_ready = 1'b0;
    push_good(4'b1000, 32'h12345678, 2'd3);
    push_good(4'b0010, 32'h87654321, 2'd1);
    wait_valid(20);
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) @(negedge clock);
      check("t2_valid_held", out_valid, 1);
      check("t2_no_refetch", fifo_re, 0);
    end
    step();
    out_ready = 1'b1;
    @(negedge clock);
    check("t2_valid_6th", out_valid, 1);
    @(negedge clock);
    check("t2_valid_drop", out_valid, 0);
    check("t2_count_once", dispatch_count, 2);
    wait_done(40);
    check("t2_count", dispatch_count, 3);

    // Malformed grants, then a good one
    step();
    push_bad(4'b0000, 32'hAAAA0000);
    wait_done(20);
    check("t3_err_zero", err_not_onehot, 1);
    check("t3_count_zero", dispatch_count, 3);
    push_bad(4'b0110, 32'hAAAA0110);
    wait_done(20);
    check("t3_err_multi", err_not_onehot, 1);
    check("t3_count_multi", dispatch_count, 3);
    push_good(4'b0001, 32'h0BADF00D, 2'd0);
    wait_done(20);
    check("t3_count_good", dispatch_count, 4);
    check("t3_err_sticky", err_not_onehot, 1);

    // Streaming four entries back to back
    step();
    push_good(4'b0001, 32'h11111111, 2'd0);
    push_good(4'b0010, 32'h22222222, 2'd1);
    push_good(4'b0100, 32'h33333333, 2'd2);
    push_good(4'b1000, 32'h44444444, 2'd3);
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      if (fifo_re) re_cyc.push_back(c);
    end
    check("t4_re_pulses", re_cyc.size(), 4);
    if (re_cyc.size() == 4) begin
      for (int k = 1; k < 4; k++) check("t4_re_period", re_cyc[k] - re_cyc[k-1], 4);
    end
    wait_done(20);
    check("t4_count", dispatch_count, 8);

    // Enable gating
    step();
    enable = 1'b0;
    out_ready = 1'b0;
    push_good(4'b0010, 32'h55AA55AA, 2'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check("t5_no_re", fifo_re, 0);
      check("t5_not_busy", busy, 0);
    end
    step();
    enable = 1'b1;
    @(negedge clock);
    check("t5_re_before_edge", fifo_re, 0);
    @(negedge clock);
    check("t5_re_after_enable", fifo_re, 1);
    wait_valid(10);
    step();
    enable = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("t5_send_survives", out_valid, 1);
    end
    step();
    out_ready = 1'b1;
    wait_done(20);
    check("t5_count", dispatch_count, 9);
    step();
    enable = 1'b1;

    // Asynchronous reset while in SEND
    step();
    out_ready = 1'b0;
    push_good(4'b0100, 32'hCAFEF00D, 2'd2);
    wait_valid(20);
    #2;
    reset = 1'b1;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_ack", mapper_ack, 0);
    check("t6_count", dispatch_count, 0);
    check("t6_err", err_not_onehot, 0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    push_good(4'b1000, 32'h600DCAFE, 2'd3);
    wait_done(20);
    check("t6_refetch_count", dispatch_count, 1);

    // Counter wrap: 17 transfers since reset with a 4-bit counter
    step();
    for (int i = 0; i < 16; i++) begin
      push_good(N'(1) << (i % 4), 32'h1000 + 32'(i), IW'(i % 4));
    end
    wait_done(150);
    check("t7_wrap_count", dispatch_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
